kn_dist_buffer: RTL and testbench

KN_DIST_BUFFER -- requirements
Module: kn_dist_buffer

---
 rtl/kn_buff_pkg.sv | 37 +++
 rtl/kn_backup_fifo.sv | 57 +++++
 rtl/kn_dist_buffer.sv | 140 ++++++++++++++
 tb/tb_kn_dist_buffer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/kn_buff_pkg.sv
// Shared constants and helpers for the KN distribution buffer: lane slice widths
// and the slot-select function that maps PE groups onto beat slots.
package kn_buff_pkg;

  localparam int DEF_NUM_PES    = 8;
  localparam int DEF_DATA_TYPE  = 16;
  localparam int DEF_LANE_W     = DEF_NUM_PES * DEF_DATA_TYPE;

  // Upper bounds for the boundary-field vector handled by slot_select.
  localparam int SEL_FIELD_BITS = 64;
  localparam int SEL_MAX_FIELDS = 32;

  function automatic int lane_width(input int num_pes, input int data_type);
    return num_pes * data_type;
  endfunction

  // Slot feeding PEG 'peg': number of boundary fields [0, last_field) whose
  // value (last PEG index of that slot) lies below 'peg'.
  function automatic int slot_select(
    input logic [SEL_FIELD_BITS-1:0] fields,
    input int                        field_w,
    input int                        last_field,
    input int                        peg
  );
    int                        cnt;
    logic [SEL_FIELD_BITS-1:0] mask;
    logic [SEL_FIELD_BITS-1:0] f;
    cnt  = 0;
    mask = (SEL_FIELD_BITS'(1) << field_w) - SEL_FIELD_BITS'(1);
    for (int i = 0; i < SEL_MAX_FIELDS; i++) begin
      f = (fields >> (i * field_w)) & mask;
      if (i < last_field && f < SEL_FIELD_BITS'(peg)) cnt++;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/kn_backup_fifo.sv
// Small synchronous first-word-fall-through FIFO holding lane slices that must be
// replayed on a later beat. Pushes into a full FIFO are dropped and flagged.
module kn_backup_fifo #(
  parameter int WIDTH      = 128,
  parameter int DEPTH      = 4,
  parameter int LOG2_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      head,
  output logic [LOG2_DEPTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow
);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [LOG2_DEPTH-1:0] wr_ptr;
  logic [LOG2_DEPTH-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty = (count == '0);
  assign full  = (count == (LOG2_DEPTH+1)'(DEPTH));
  assign head  = mem[rd_ptr];

  // A pop frees a slot in the same cycle, so a full FIFO still accepts push+pop.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !do_push) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/kn_dist_buffer.sv
// Distributes up to PARA_BLOCKS lane heads (plus an optional replayed backup slice)
// across NUM_PEGS PE groups per beat, with a registered output bus.
module kn_dist_buffer
  import kn_buff_pkg::*;
#(
  parameter int NUM_PEGS          = 4,
  parameter int LOG2_PEGS         = 2,
  parameter int NUM_PES           = 8,
  parameter int DATA_TYPE         = 16,
  parameter int PARA_BLOCKS       = 4,
  parameter int LOG2_PARA_BLOCKS  = 2,
  parameter int BACKUP_DEPTH      = 4,
  parameter int LOG2_BACKUP_DEPTH = 2
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [PARA_BLOCKS*NUM_PES*DATA_TYPE-1:0]  i_fifo_KN_data_out,
  input  logic                                      i_fifo_KN_data_empty,
  input  logic                                      data_source,
  input  logic                                      KN_counter_ena,
  input  logic                                      i_flush,
  input  logic [1:0]                                i_backup_fifo_ena,
  input  logic [LOG2_PARA_BLOCKS:0]                 i_block_counter,
  input  logic [LOG2_PEGS*PARA_BLOCKS-1:0]          i_peg_num_counter,
  output logic [NUM_PEGS*NUM_PES*DATA_TYPE-1:0]     o_KN_data_bus,
  output logic                                      o_KN_data_valid,
  output logic [PARA_BLOCKS-1:0]                    o_fifo_KN_rd_en,
  output logic [LOG2_BACKUP_DEPTH:0]                o_backup_count,
  output logic                                      o_backup_full,
  output logic                                      o_backup_empty,
  output logic                                      o_backup_overflow
);

  localparam int LANE_W = lane_width(NUM_PES, DATA_TYPE);
  localparam int PL     = LOG2_PARA_BLOCKS;
  localparam int SW     = LOG2_PARA_BLOCKS + 2;

  logic [PL-1:0]                 ptr;
  logic [PL-1:0]                 ptr_next;
  logic                          fire;
  logic                          use_bk;
  logic                          bk_push;
  logic                          bk_pop;
  logic [SW-1:0]                 slots;
  logic [SW-1:0]                 consumed;
  logic [SW-1:0]                 ptr_sum;
  logic [LANE_W-1:0]             bk_head;
  logic [LANE_W-1:0]             push_data;
  logic [NUM_PEGS*LANE_W-1:0]    routed;

  // Slot/lane accounting: slot 0 is the backup head when a pop is taken, so the
  // lanes actually read this beat are the remaining S - use_bk slots.
  always_comb begin
    fire     = !data_source && !KN_counter_ena && !i_fifo_KN_data_empty && !i_flush && !rst;
    use_bk   = i_backup_fifo_ena[1] && !o_backup_empty;
    slots    = SW'(i_block_counter) + SW'(1);
    consumed = slots - SW'(use_bk);
    ptr_sum  = SW'(ptr) + consumed;
    ptr_next = (ptr_sum >= SW'(PARA_BLOCKS)) ? PL'(ptr_sum - SW'(PARA_BLOCKS)) : PL'(ptr_sum);
    bk_push  = fire && i_backup_fifo_ena[0];
    bk_pop   = fire && use_bk;
  end

  always_comb begin
    int off;
    off             = 0;
    o_fifo_KN_rd_en = '0;
    for (int b = 0; b < PARA_BLOCKS; b++) begin
      off = (b >= int'(ptr)) ? (b - int'(ptr)) : (b + PARA_BLOCKS - int'(ptr));
      o_fifo_KN_rd_en[b] = fire && (off < int'(consumed));
    end
  end

  // The pushed slice is the last lane read this beat, or the head itself when no
  // lane is read (recycling the backup entry to the tail).
  always_comb begin
    int last;
    last      = 0;
    push_data = bk_head;
    if (consumed != '0) begin
      last = int'(ptr) + int'(consumed) - 1;
      if (last >= PARA_BLOCKS) last = last - PARA_BLOCKS;
      push_data = i_fifo_KN_data_out[last*LANE_W +: LANE_W];
    end
  end

  always_comb begin
    int s;
    int lane;
    s      = 0;
    lane   = 0;
    routed = '0;
    for (int j = 0; j < NUM_PEGS; j++) begin
      s = slot_select(SEL_FIELD_BITS'(i_peg_num_counter), LOG2_PEGS, int'(slots) - 1, j);
      if (use_bk && s == 0) begin
        routed[j*LANE_W +: LANE_W] = bk_head;
      end else begin
        lane = int'(ptr) + s - int'(use_bk);
        if (lane >= PARA_BLOCKS) lane = lane - PARA_BLOCKS;
        routed[j*LANE_W +: LANE_W] = i_fifo_KN_data_out[lane*LANE_W +: LANE_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr             <= '0;
      o_KN_data_bus   <= '0;
      o_KN_data_valid <= 1'b0;
    end else if (i_flush) begin
      ptr             <= '0;
      o_KN_data_valid <= 1'b0;
    end else if (fire) begin
      ptr             <= ptr_next;
      o_KN_data_bus   <= routed;
      o_KN_data_valid <= 1'b1;
    end else begin
      o_KN_data_valid <= 1'b0;
    end
  end

  kn_backup_fifo #(
    .WIDTH      (LANE_W),
    .DEPTH      (BACKUP_DEPTH),
    .LOG2_DEPTH (LOG2_BACKUP_DEPTH)
  ) u_backup (
    .clk      (clk),
    .rst      (rst),
    .clear    (i_flush),
    .push     (bk_push),
    .pop      (bk_pop),
    .din      (push_data),
    .head     (bk_head),
    .count    (o_backup_count),
    .full     (o_backup_full),
    .empty    (o_backup_empty),
    .overflow (o_backup_overflow)
  );

endmodule

// File: tb/tb_kn_dist_buffer.sv
// Directed bench for kn_dist_buffer with default parameters (4 lanes, 4 PEGs,
// backup depth 4); expected values are hand-derived lane/PEG mappings.
module tb_kn_dist_buffer;

  logic         clk;
  logic         rst;
  logic [511:0] lanes;
  logic         kn_empty;
  logic         data_source;
  logic         kn_counter_ena;
  logic         flush;
  logic [1:0]   bk_ena;
  logic [2:0]   block_counter;
  logic [7:0]   peg_num;
  logic [511:0] bus;
  logic         valid;
  logic [3:0]   rd_en;
  logic [2:0]   bk_count;
  logic         bk_full;
  logic         bk_empty;
  logic         bk_ovf;

  int passed;
  int total;

  kn_dist_buffer dut (
    .clk                  (clk),
    .rst                  (rst),
    .i_fifo_KN_data_out   (lanes),
    .i_fifo_KN_data_empty (kn_empty),
    .data_source          (data_source),
    .KN_counter_ena       (kn_counter_ena),
    .i_flush              (flush),
    .i_backup_fifo_ena    (bk_ena),
    .i_block_counter      (block_counter),
    .i_peg_num_counter    (peg_num),
    .o_KN_data_bus        (bus),
    .o_KN_data_valid      (valid),
    .o_fifo_KN_rd_en      (rd_en),
    .o_backup_count       (bk_count),
    .o_backup_full        (bk_full),
    .o_backup_empty       (bk_empty),
    .o_backup_overflow    (bk_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] lv(input int tag, input int b);
    logic [15:0] e;
    e = 16'(tag * 16 + b);
    return {8{e}};
  endfunction

  function automatic logic [511:0] lane_set(input int tag);
    return {lv(tag, 3), lv(tag, 2), lv(tag, 1), lv(tag, 0)};
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [2:0] bc, input logic [7:0] pn, input logic [1:0] ena);
    data_source   = 1'b0;
    block_counter = bc;
    peg_num       = pn;
    bk_ena        = ena;
    #1;
  endtask

  task automatic idle();
    data_source = 1'b1;
    bk_ena      = 2'b00;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst = 1'b1; lanes = lane_set(1); kn_empty = 1'b0; data_source = 1'b0;
    kn_counter_ena = 1'b0; flush = 1'b0; bk_ena = 2'b01; block_counter = 3'd1; peg_num = 8'h00;

    // Reset held two cycles with requests asserted.
    tick();
    tick();
    chk("rst_rd_en", 512'(rd_en), 512'(4'b0000));
    chk("rst_bus", bus, '0);
    chk("rst_valid", 512'(valid), 512'(1'b0));
    chk("rst_count", 512'(bk_count), 512'(3'd0));
    chk("rst_empty", 512'(bk_empty), 512'(1'b1));
    chk("rst_full", 512'(bk_full), 512'(1'b0));
    chk("rst_ovf", 512'(bk_ovf), 512'(1'b0));
    rst = 1'b0;
    idle();
    tick();

    // ptr 0, two slots, field0 = 1.
    req(3'd1, 8'h01, 2'b00);
    chk("two_slot_rd_en", 512'(rd_en), 512'(4'b0011));
    tick(); idle();
    chk("two_slot_valid", 512'(valid), 512'(1'b1));
    chk("two_slot_bus", bus, {lv(1, 1), lv(1, 1), lv(1, 0), lv(1, 0)});
    tick();
    chk("idle_valid", 512'(valid), 512'(1'b0));
    chk("idle_bus_hold", bus, {lv(1, 1), lv(1, 1), lv(1, 0), lv(1, 0)});

    // ptr 2 -> 3 with a single slot.
    req(3'd0, 8'h00, 2'b00);
    chk("ptr2_rd_en", 512'(rd_en), 512'(4'b0100));
    tick(); idle();
    chk("ptr2_bus", bus, {4{lv(1, 2)}});

    // Wrap: ptr 3, three slots, fields f0=1 f1=2.
    req(3'd2, 8'h09, 2'b00);
    chk("wrap_rd_en", 512'(rd_en), 512'(4'b1011));
    tick(); idle();
    chk("wrap_bus", bus, {lv(1, 1), lv(1, 0), lv(1, 3), lv(1, 3)});

    // ptr 2 -> 0.
    req(3'd1, 8'h00, 2'b00);
    chk("ptr_to0_rd_en", 512'(rd_en), 512'(4'b1100));
    tick(); idle();
    chk("ptr_to0_bus", bus, {lv(1, 3), lv(1, 3), lv(1, 3), lv(1, 2)});

    // Push lane 0 into backup, then replay it in slot 0 with fresh lane data.
    req(3'd0, 8'h00, 2'b01);
    chk("push_rd_en", 512'(rd_en), 512'(4'b0001));
    tick(); idle();
    chk("push_count", 512'(bk_count), 512'(3'd1));
    chk("push_empty", 512'(bk_empty), 512'(1'b0));
    lanes = lane_set(2);
    req(3'd1, 8'h00, 2'b10);
    chk("pop_rd_en", 512'(rd_en), 512'(4'b0010));
    tick(); idle();
    chk("pop_bus", bus, {lv(2, 1), lv(2, 1), lv(2, 1), lv(1, 0)});
    chk("pop_count", 512'(bk_count), 512'(3'd0));
    chk("pop_empty", 512'(bk_empty), 512'(1'b1));

    // Five single-lane pushes from ptr 2: lanes 2,3,0,1,2.
    lanes = lane_set(3);
    for (int k = 0; k < 5; k++) begin
      req(3'd0, 8'h00, 2'b01);
      tick();
      if (k == 3) begin
        chk("fill_full", 512'(bk_full), 512'(1'b1));
        chk("fill_count", 512'(bk_count), 512'(3'd4));
        chk("fill_no_ovf", 512'(bk_ovf), 512'(1'b0));
      end
    end
    idle();
    chk("ovf_set", 512'(bk_ovf), 512'(1'b1));
    chk("ovf_count", 512'(bk_count), 512'(3'd4));

    // Full: pop+push of the head with no lane read keeps the count.
    req(3'd0, 8'h00, 2'b11);
    chk("recycle_rd_en", 512'(rd_en), 512'(4'b0000));
    tick(); idle();
    chk("recycle_bus", bus, {4{lv(3, 2)}});
    chk("recycle_count", 512'(bk_count), 512'(3'd4));
    chk("recycle_valid", 512'(valid), 512'(1'b1));
    req(3'd0, 8'h00, 2'b10);
    tick(); idle();
    chk("pop_only_bus", bus, {4{lv(3, 3)}});
    chk("pop_only_count", 512'(bk_count), 512'(3'd3));

    // Flush wins over an active request.
    req(3'd1, 8'h00, 2'b01);
    flush = 1'b1;
    #1;
    chk("flush_rd_en", 512'(rd_en), 512'(4'b0000));
    tick(); idle(); flush = 1'b0;
    chk("flush_count", 512'(bk_count), 512'(3'd0));
    chk("flush_ovf", 512'(bk_ovf), 512'(1'b0));
    chk("flush_valid", 512'(valid), 512'(1'b0));
    req(3'd0, 8'h00, 2'b00);
    chk("flush_ptr0", 512'(rd_en), 512'(4'b0001));
    tick(); idle();

    // Stalls: data_source, lane empty, counter enable; ptr (1) and backup hold.
    data_source = 1'b1; bk_ena = 2'b01; block_counter = 3'd2; #1;
    chk("ds_rd_en", 512'(rd_en), 512'(4'b0000));
    tick();
    chk("ds_valid", 512'(valid), 512'(1'b0));
    chk("ds_count", 512'(bk_count), 512'(3'd0));
    data_source = 1'b0; kn_empty = 1'b1; #1;
    chk("empty_rd_en", 512'(rd_en), 512'(4'b0000));
    tick();
    chk("empty_valid", 512'(valid), 512'(1'b0));
    kn_empty = 1'b0; kn_counter_ena = 1'b1; #1;
    chk("cnt_ena_rd_en", 512'(rd_en), 512'(4'b0000));
    tick();
    kn_counter_ena = 1'b0;
    chk("stall_count", 512'(bk_count), 512'(3'd0));
    req(3'd0, 8'h00, 2'b01);
    chk("stall_ptr_hold", 512'(rd_en), 512'(4'b0010));
    tick(); idle();
    chk("stall_push_count", 512'(bk_count), 512'(3'd1));

    // Reset mid-operation discards backup contents.
    req(3'd0, 8'h00, 2'b01);
    rst = 1'b1;
    #1;
    chk("midrst_rd_en", 512'(rd_en), 512'(4'b0000));
    tick(); rst = 1'b0; idle();
    chk("midrst_count", 512'(bk_count), 512'(3'd0));
    chk("midrst_empty", 512'(bk_empty), 512'(1'b1));
    chk("midrst_valid", 512'(valid), 512'(1'b0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
